// File: rtl/jtcontra_obj_pkg.sv
// Shared types and widths for the Contra OBJ sprite ROM responder.
package jtcontra_obj_pkg;

   localparam int OBJ_AW   = 18;
   localparam int OBJ_DW   = 16;
   localparam int SDRAM_AW = 22;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } state_e;

endpackage

// File: rtl/jtcontra_obj_romrq_tags.sv
// Two-entry tag/data/valid store with combinational lookup, one write port and flush.
module jtcontra_obj_romrq_tags
   import jtcontra_obj_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush_i,
   input  logic [OBJ_AW-1:0] lk_addr_i,
   output logic              hit_o,
   output logic [OBJ_DW-1:0] hit_data_o,
   input  logic              wr_en_i,
   input  logic              wr_idx_i,
   input  logic [OBJ_AW-1:0] wr_tag_i,
   input  logic [OBJ_DW-1:0] wr_data_i,
   input  logic              wr_valid_i
);

   logic [OBJ_AW-1:0] tag_q  [2];
   logic [OBJ_DW-1:0] data_q [2];
   logic [1:0]        valid_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         for (int i = 0; i < 2; i++) begin
            tag_q[i]  <= '0;
            data_q[i] <= '0;
         end
      end else begin
         if (wr_en_i) begin
            tag_q[wr_idx_i]   <= wr_tag_i;
            data_q[wr_idx_i]  <= wr_data_i;
            valid_q[wr_idx_i] <= wr_valid_i;
         end
         // Flush overrides a fill landing in the same cycle.
         if (flush_i) valid_q <= '0;
      end
   end

   always_comb begin
      hit_o      = 1'b0;
      hit_data_o = '0;
      for (int i = 0; i < 2; i++) begin
         if (valid_q[i] && tag_q[i] == lk_addr_i) begin
            hit_o      = 1'b1;
            hit_data_o = data_q[i];
         end
      end
   end

endmodule

// File: rtl/jtcontra_obj_romrq.sv
// OBJ sprite ROM responder: 2-entry word cache in front of single-word SDRAM reads.
// Handshake: sdram_req stays high until sdram_ack; data_rdy qualifies sdram_din for one cycle.
module jtcontra_obj_romrq
   import jtcontra_obj_pkg::*;
#(
   parameter logic [SDRAM_AW-1:0] OFFSET = 22'h0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                flush,
   input  logic                rom_cs,
   input  logic [OBJ_AW-1:0]   rom_addr,
   output logic                rom_ok,
   output logic [OBJ_DW-1:0]   rom_data,
   output logic                sdram_req,
   output logic [SDRAM_AW-1:0] sdram_addr,
   input  logic                sdram_ack,
   input  logic                data_rdy,
   input  logic [OBJ_DW-1:0]   sdram_din,
   output state_e              dbg_state
);

   state_e              state_q, state_d;
   logic [OBJ_AW-1:0]   req_addr_q, req_addr_d;
   logic                rr_q, rr_d;
   logic                drop_q, drop_d;
   logic                rom_ok_q, rom_ok_d;
   logic [OBJ_DW-1:0]   rom_data_q, rom_data_d;
   logic                sdram_req_q, sdram_req_d;
   logic [SDRAM_AW-1:0] sdram_addr_q, sdram_addr_d;

   logic                hit;
   logic [OBJ_DW-1:0]   hit_data;
   logic                fill;

   jtcontra_obj_romrq_tags u_tags (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush_i    (flush),
      .lk_addr_i  (rom_addr),
      .hit_o      (hit),
      .hit_data_o (hit_data),
      .wr_en_i    (fill),
      .wr_idx_i   (rr_q),
      .wr_tag_i   (req_addr_q),
      .wr_data_i  (sdram_din),
      .wr_valid_i (!(drop_q || flush))
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         req_addr_q   <= '0;
         rr_q         <= 1'b0;
         drop_q       <= 1'b0;
         rom_ok_q     <= 1'b0;
         rom_data_q   <= '0;
         sdram_req_q  <= 1'b0;
         sdram_addr_q <= OFFSET;
      end else begin
         state_q      <= state_d;
         req_addr_q   <= req_addr_d;
         rr_q         <= rr_d;
         drop_q       <= drop_d;
         rom_ok_q     <= rom_ok_d;
         rom_data_q   <= rom_data_d;
         sdram_req_q  <= sdram_req_d;
         sdram_addr_q <= sdram_addr_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      req_addr_d   = req_addr_q;
      rr_d         = rr_q;
      drop_d       = drop_q;
      rom_ok_d     = 1'b0;
      rom_data_d   = rom_data_q;
      sdram_req_d  = sdram_req_q;
      sdram_addr_d = sdram_addr_q;
      fill         = 1'b0;

      // Hits are served in every state, including while a miss is pending.
      if (rom_cs && hit) begin
         rom_ok_d   = 1'b1;
         rom_data_d = hit_data;
      end

      case (state_q)
         ST_IDLE: begin
            if (rom_cs && !hit) begin
               req_addr_d   = rom_addr;
               sdram_addr_d = OFFSET + {4'b0, rom_addr};
               sdram_req_d  = 1'b1;
               drop_d       = 1'b0;
               state_d      = ST_REQ;
            end
         end
         ST_REQ: begin
            if (sdram_ack) begin
               sdram_req_d = 1'b0;
               if (data_rdy) fill = 1'b1;
               else          state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (data_rdy) fill = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase

      if (fill) begin
         rr_d    = ~rr_q;
         state_d = ST_IDLE;
         if (!drop_q && rom_cs && rom_addr == req_addr_q) begin
            rom_ok_d   = 1'b1;
            rom_data_d = sdram_din;
         end
      end

      // A flushed pending fill must neither validate its entry nor raise rom_ok.
      if (flush) begin
         drop_d     = 1'b1;
         rom_ok_d   = 1'b0;
         rom_data_d = rom_data_q;
      end
   end

   assign rom_ok     = rom_ok_q;
   assign rom_data   = rom_data_q;
   assign sdram_req  = sdram_req_q;
   assign sdram_addr = sdram_addr_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_jtcontra_obj_romrq.sv
// Directed bench for jtcontra_obj_romrq: cycle-by-cycle compare against a cache model plus literal checks.
module tb_jtcontra_obj_romrq;
   import jtcontra_obj_pkg::*;

   localparam logic [21:0] OFF = 22'h100000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        rom_cs = 1'b0;
   logic [17:0] rom_addr = '0;
   logic        rom_ok;
   logic [15:0] rom_data;
   logic        sdram_req;
   logic [21:0] sdram_addr;
   logic        sdram_ack = 1'b0;
   logic        data_rdy = 1'b0;
   logic [15:0] sdram_din = '0;
   state_e      dbg_state;

   int n_vec = 0;
   int n_err = 0;

   jtcontra_obj_romrq #(.OFFSET(OFF)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .rom_cs     (rom_cs),
      .rom_addr   (rom_addr),
      .rom_ok     (rom_ok),
      .rom_data   (rom_data),
      .sdram_req  (sdram_req),
      .sdram_addr (sdram_addr),
      .sdram_ack  (sdram_ack),
      .data_rdy   (data_rdy),
      .sdram_din  (sdram_din),
      .dbg_state  (dbg_state)
   );

   always #5 clk = ~clk;

   // ---------------- model: cache contents plus one outstanding read ----------------
   logic        m_valid [2] = '{1'b0, 1'b0};
   logic [17:0] m_tag   [2] = '{18'h0, 18'h0};
   logic [15:0] m_data  [2] = '{16'h0, 16'h0};
   logic        m_rr = 1'b0;
   logic        m_pend = 1'b0;
   logic        m_acked = 1'b0;
   logic        m_drop = 1'b0;
   logic [17:0] m_raddr = '0;
   logic        exp_ok = 1'b0;
   logic [15:0] exp_data = '0;
   logic        exp_req = 1'b0;
   logic [21:0] exp_addr = OFF;
   logic        m_hit;
   logic [15:0] m_hd;
   logic        n_ok;
   logic [15:0] n_data;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid = '{1'b0, 1'b0};
         m_rr = 1'b0; m_pend = 1'b0; m_acked = 1'b0; m_drop = 1'b0;
         exp_ok = 1'b0; exp_data = '0; exp_req = 1'b0; exp_addr = OFF;
      end else begin
         m_hit = 1'b0;
         m_hd  = '0;
         for (int i = 0; i < 2; i++)
            if (m_valid[i] && m_tag[i] == rom_addr) begin m_hit = 1'b1; m_hd = m_data[i]; end
         n_ok   = rom_cs && m_hit;
         n_data = n_ok ? m_hd : exp_data;
         if (!m_pend) begin
            if (rom_cs && !m_hit) begin
               m_pend = 1'b1; m_acked = 1'b0; m_drop = 1'b0; m_raddr = rom_addr;
               exp_req = 1'b1; exp_addr = OFF + {4'b0, rom_addr};
            end
         end else begin
            if (!m_acked && sdram_ack) begin m_acked = 1'b1; exp_req = 1'b0; end
            if (m_acked && data_rdy) begin
               m_tag[m_rr] = m_raddr; m_data[m_rr] = sdram_din;
               m_valid[m_rr] = !(m_drop || flush);
               m_rr = !m_rr; m_pend = 1'b0;
               if (!m_drop && rom_cs && rom_addr == m_raddr) begin n_ok = 1'b1; n_data = sdram_din; end
            end
         end
         if (flush) begin
            m_valid = '{1'b0, 1'b0}; m_drop = 1'b1; n_ok = 1'b0; n_data = exp_data;
         end
         exp_ok = n_ok;
         exp_data = n_data;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      chk("model_rom_ok", {31'b0, rom_ok}, {31'b0, exp_ok});
      chk("model_rom_data", {16'b0, rom_data}, {16'b0, exp_data});
      chk("model_sdram_req", {31'b0, sdram_req}, {31'b0, exp_req});
      chk("model_sdram_addr", {10'b0, sdram_addr}, {10'b0, exp_addr});
   end

   // ---------------- drivers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Called in the cycle a miss on addr is presented; ack after a cycles, data d cycles later.
   task automatic serve(input logic [17:0] addr, input int a, input int d, input logic [15:0] w);
      for (int k = 1; k <= a + d + 1; k++) begin
         step();
         if (k == 1) begin
            chk("miss_req", {31'b0, sdram_req}, 32'd1);
            chk("miss_addr", {10'b0, sdram_addr}, {10'b0, OFF + {4'b0, addr}});
         end
         sdram_ack = (k == a);
         data_rdy  = (k == a + d);
         sdram_din = (k == a + d) ? w : 16'h0;
      end
      chk("fill_ok", {31'b0, rom_ok}, 32'd1);
      chk("fill_data", {16'b0, rom_data}, {16'b0, w});
   endtask

   task automatic miss(input logic [17:0] addr, input int a, input int d, input logic [15:0] w);
      rom_cs = 1'b1;
      rom_addr = addr;
      serve(addr, a, d, w);
   endtask

   task automatic present_hit(input logic [17:0] addr, input logic [15:0] w);
      rom_cs = 1'b1;
      rom_addr = addr;
      step();
      chk("hit_ok", {31'b0, rom_ok}, 32'd1);
      chk("hit_data", {16'b0, rom_data}, {16'b0, w});
      chk("hit_no_req", {31'b0, sdram_req}, 32'd0);
   endtask

   initial begin
      repeat (3) step();
      chk("rst_rom_ok", {31'b0, rom_ok}, 32'd0);
      chk("rst_rom_data", {16'b0, rom_data}, 32'd0);
      chk("rst_sdram_req", {31'b0, sdram_req}, 32'd0);
      chk("rst_sdram_addr", {10'b0, sdram_addr}, 32'h00100000);
      rst_n = 1'b1;
      step();

      // Cold miss on 0x123: ack at +3, data at +5.
      miss(18'h00123, 3, 2, 16'hBEEF);
      rom_cs = 1'b0;
      step();
      chk("cs_low_ok", {31'b0, rom_ok}, 32'd0);
      chk("cs_low_data_hold", {16'b0, rom_data}, 32'h0000BEEF);
      present_hit(18'h00123, 16'hBEEF);

      // Ack and data together one cycle after the miss.
      miss(18'h00040, 1, 0, 16'h4040);
      step();
      chk("same_cycle_req_low", {31'b0, sdram_req}, 32'd0);

      // Replacement: 0x12 evicts 0x10.
      miss(18'h00010, 2, 1, 16'h1010);
      miss(18'h00011, 1, 3, 16'h1111);
      miss(18'h00012, 2, 2, 16'h1212);
      present_hit(18'h00011, 16'h1111);
      miss(18'h00010, 1, 1, 16'h1011);
      miss(18'h00011, 1, 1, 16'h1112);

      // Address change during WAIT to cached 0x11.
      rom_cs = 1'b1; rom_addr = 18'h00020;
      step(); sdram_ack = 1'b1;
      step(); sdram_ack = 1'b0; rom_addr = 18'h00011;
      step();
      chk("switch_hit_ok", {31'b0, rom_ok}, 32'd1);
      chk("switch_hit_data", {16'b0, rom_data}, 32'h00001112);
      data_rdy = 1'b1; sdram_din = 16'h2020;
      step(); data_rdy = 1'b0; sdram_din = '0;
      chk("switch_fill_hidden", {16'b0, rom_data}, 32'h00001112);
      present_hit(18'h00020, 16'h2020);

      // Flush while the 0x30 fill is pending.
      rom_addr = 18'h00030;
      step(); sdram_ack = 1'b1;
      step(); sdram_ack = 1'b0; rom_addr = 18'h00020;
      step();
      chk("pre_flush_ok", {31'b0, rom_ok}, 32'd1);
      flush = 1'b1;
      step(); flush = 1'b0; rom_addr = 18'h00030;
      chk("flush_ok_low", {31'b0, rom_ok}, 32'd0);
      step(); data_rdy = 1'b1; sdram_din = 16'h3030;
      step(); data_rdy = 1'b0; sdram_din = '0;
      chk("dropped_fill_ok", {31'b0, rom_ok}, 32'd0);
      serve(18'h00030, 1, 0, 16'h3031);
      present_hit(18'h00030, 16'h3031);

      // Reset in the middle of a request.
      rom_addr = 18'h00055;
      step();
      chk("pre_reset_req", {31'b0, sdram_req}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("async_reset_req", {31'b0, sdram_req}, 32'd0);
      chk("async_reset_ok", {31'b0, rom_ok}, 32'd0);
      rom_cs = 1'b0;
      step();
      rst_n = 1'b1;
      repeat (3) step();
      chk("post_reset_addr", {10'b0, sdram_addr}, 32'h00100000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
